lap_stopwatch: RTL and testbench

- Next-generation stopwatch/timer core: six BCD digits (MM:SS.cc), up-count or countdown mode, start/stop FSM, lap/split capture, load of a preset and a threshold alarm.
- Sits between the debounced button pulses and the seven-segment display driver.
- Replaces the fixed 60 s up-counter control block.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 39 +++
 rtl/lap_stopwatch.sv | 173 +++++++++++++++++
 tb/tb_lap_stopwatch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state type, digit layout and conversion helper for the lap_stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP, DONE} state_e;

    localparam int unsigned CS_L       = 0;
    localparam int unsigned CS_H       = 1;
    localparam int unsigned SEC_L      = 2;
    localparam int unsigned SEC_H      = 3;
    localparam int unsigned MIN_L      = 4;
    localparam int unsigned MIN_H      = 5;
    localparam int unsigned NUM_DIGITS = 6;

    localparam int unsigned CS_L_MAX  = 9;
    localparam int unsigned CS_H_MAX  = 9;
    localparam int unsigned SEC_L_MAX = 9;
    localparam int unsigned SEC_H_MAX = 5;
    localparam int unsigned MIN_L_MAX = 9;

    localparam int unsigned CS_PER_SEC = 100;

    function automatic int unsigned bcd_to_cs(input logic [23:0] bcd);
        return 32'(bcd[MIN_H*4 +: 4]) * 32'd60000 + 32'(bcd[MIN_L*4 +: 4]) * 32'd6000
             + 32'(bcd[SEC_H*4 +: 4]) * 32'd1000 + 32'(bcd[SEC_L*4 +: 4]) * 32'd100
             + 32'(bcd[CS_H*4 +: 4]) * 32'd10 + 32'(bcd[CS_L*4 +: 4]);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch cascade: saturating load, wrapping increment/decrement.
module bcd_digit #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] val,
    output logic       carry,
    output logic       borrow
);

    localparam logic [3:0] MaxVal = 4'(MAX);

    logic [3:0] r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
        end else if (clr) begin
            r_val <= '0;
        end else if (load) begin
            r_val <= (load_val > MaxVal) ? MaxVal : load_val;
        end else if (inc) begin
            r_val <= (r_val == MaxVal) ? 4'd0 : r_val + 4'd1;
        end else if (dec) begin
            r_val <= (r_val == 4'd0) ? MaxVal : r_val - 4'd1;
        end
    end

    assign val    = r_val;
    assign carry  = inc && (r_val == MaxVal);
    assign borrow = dec && (r_val == 4'd0);

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.cc stopwatch/timer: up/down count, start/stop FSM, lap capture, threshold alarm.
// Defining LAP_HISTORY_EN adds a LAP_DEPTH-entry lap history read through hist_idx/hist_bcd.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_H_MAX = 5,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ALARM_SEC = 10,
    parameter int unsigned LAP_W     = 4,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                         clk_100hz,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         mode_down,
    input  logic [23:0]                  load_bcd,
`ifdef LAP_HISTORY_EN
    input  logic [$clog2(LAP_DEPTH)-1:0] hist_idx,
    output logic [23:0]                  hist_bcd,
`endif
    output logic [23:0]                  disp_bcd,
    output logic                         running,
    output logic                         lap_active,
    output logic [LAP_W-1:0]             lap_count,
    output logic                         time_out,
    output logic                         done
);

    localparam int unsigned AlarmCs   = ALARM_SEC * CS_PER_SEC;
    localparam logic [15:0] PrescLast = 16'(TICK_DIV - 1);

    state_e                r_state, w_state_next;
    logic [15:0]           r_presc;
    logic [23:0]           r_snap, r_disp, w_live;
    logic                  r_lap_active, r_done, r_time_out;
    logic [LAP_W-1:0]      r_lap_count;
    logic                  w_tick, w_tick_up, w_tick_down, w_reach_zero, w_live_zero;
    logic                  w_load_ok, w_lap_run, w_lap_stop, w_unused;
    logic [NUM_DIGITS-1:0] w_inc, w_dec, w_carry, w_borrow;
    int unsigned           w_live_cs;

    assign w_live_cs    = bcd_to_cs(w_live);
    assign w_live_zero  = (w_live == 24'd0);
    assign w_tick       = (r_state == RUN) && (r_presc == PrescLast);
    assign w_tick_up    = w_tick && !mode_down;
    // Down count never wraps: a tick at zero is swallowed.
    assign w_tick_down  = w_tick && mode_down && !w_live_zero;
    assign w_reach_zero = w_tick && mode_down && (w_live_cs <= 32'd1);
    assign w_load_ok    = load && !clear && (r_state != RUN);
    assign w_lap_run    = lap && !clear && !start_stop && (r_state == RUN);
    assign w_lap_stop   = lap && !clear && !load && !start_stop && (r_state == STOP);

    assign w_inc    = {w_carry[NUM_DIGITS-2:0], w_tick_up};
    assign w_dec    = {w_borrow[NUM_DIGITS-2:0], w_tick_down};
    assign w_unused = ^{w_carry[MIN_H], w_borrow[MIN_H]};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int unsigned DigitMax = (i == MIN_H) ? MIN_H_MAX :
                                           (i == MIN_L) ? MIN_L_MAX :
                                           (i == SEC_H) ? SEC_H_MAX :
                                           (i == SEC_L) ? SEC_L_MAX :
                                           (i == CS_H)  ? CS_H_MAX  : CS_L_MAX;
        bcd_digit #(
            .MAX(DigitMax)
        ) u_digit (
            .clk     (clk_100hz),
            .rst     (rst),
            .clr     (clear),
            .load    (w_load_ok),
            .load_val(load_bcd[i*4 +: 4]),
            .inc     (w_inc[i]),
            .dec     (w_dec[i]),
            .val     (w_live[i*4 +: 4]),
            .carry   (w_carry[i]),
            .borrow  (w_borrow[i])
        );
    end

    always_comb begin
        w_state_next = r_state;
        if (clear || w_load_ok) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (start_stop && !(mode_down && w_live_zero)) w_state_next = RUN;
                RUN: begin
                    if (w_reach_zero)    w_state_next = DONE;
                    else if (start_stop) w_state_next = STOP;
                end
                STOP: if (start_stop) w_state_next = RUN;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_snap       <= '0;
            r_disp       <= '0;
            r_lap_active <= 1'b0;
            r_lap_count  <= '0;
            r_done       <= 1'b0;
            r_time_out   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Prescaler holds outside RUN so a resume keeps the partial tick.
            if (clear) begin
                r_presc <= '0;
            end else if (r_state == RUN) begin
                r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            end
            if (clear) begin
                r_snap       <= '0;
                r_lap_active <= 1'b0;
                r_lap_count  <= '0;
                r_done       <= 1'b0;
            end else if (w_load_ok) begin
                r_lap_active <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                if (w_lap_run) begin
                    r_snap       <= w_live;
                    r_lap_active <= 1'b1;
                    if (r_lap_count != '1) r_lap_count <= r_lap_count + LAP_W'(1);
                end else if (w_lap_stop) begin
                    r_lap_active <= 1'b0;
                end
                if (w_reach_zero) r_done <= 1'b1;
            end
            r_disp     <= r_lap_active ? r_snap : w_live;
            r_time_out <= mode_down ? ((w_live_cs != 32'd0) && (w_live_cs < AlarmCs))
                                    : (w_live_cs >= AlarmCs);
        end
    end

`ifdef LAP_HISTORY_EN
    logic [23:0] r_hist [LAP_DEPTH];
    logic [23:0] r_hist_bcd;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) r_hist[i] <= '0;
            r_hist_bcd <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < LAP_DEPTH; i++) r_hist[i] <= '0;
            end else if (w_lap_run) begin
                r_hist[0] <= w_live;
                for (int i = 1; i < LAP_DEPTH; i++) r_hist[i] <= r_hist[i-1];
            end
            r_hist_bcd <= r_hist[hist_idx];
        end
    end

    assign hist_bcd = r_hist_bcd;
`else
    logic [31:0] w_unused_depth;
    assign w_unused_depth = 32'(LAP_DEPTH);
`endif

    assign disp_bcd   = r_disp;
    assign running    = (r_state == RUN);
    assign lap_active = r_lap_active;
    assign lap_count  = r_lap_count;
    assign time_out   = r_time_out;
    assign done       = r_done;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: expected outputs are queued with a due cycle and compared on negedge.
module tb_lap_stopwatch;

    // Stimulus timing below assumes four clocks per centisecond tick.
    localparam int unsigned TickDiv = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0, lap = 1'b0, clear = 1'b0, load = 1'b0, mode_down = 1'b0;
    logic [23:0] load_bcd = '0;
    logic [23:0] disp_bcd;
    logic        running, lap_active, time_out, done;
    logic [3:0]  lap_count;
`ifdef LAP_HISTORY_EN
    logic [1:0]  hist_idx = '0;
    logic [23:0] hist_bcd;
`endif

    typedef struct {
        int unsigned due;
        string       tag;
        logic [23:0] disp;
        logic        run;
        logic        lapa;
        logic [3:0]  lapc;
        logic        tout;
        logic        dn;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    lap_stopwatch #(
        .MIN_H_MAX(5),
        .TICK_DIV (TickDiv),
        .ALARM_SEC(10),
        .LAP_W    (4),
        .LAP_DEPTH(4)
    ) dut (
        .clk_100hz (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .load      (load),
        .mode_down (mode_down),
        .load_bcd  (load_bcd),
`ifdef LAP_HISTORY_EN
        .hist_idx  (hist_idx),
        .hist_bcd  (hist_bcd),
`endif
        .disp_bcd  (disp_bcd),
        .running   (running),
        .lap_active(lap_active),
        .lap_count (lap_count),
        .time_out  (time_out),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int unsigned cs);
        int unsigned m = cs / 6000;
        int unsigned s = (cs / 100) % 60;
        int unsigned c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic expect_at(input int unsigned dt, input string tag, input int unsigned cs,
                             input logic run, input logic lapa, input int unsigned lapc,
                             input logic tout, input logic dn);
        exp_t e;
        e.due  = cyc + dt;
        e.tag  = tag;
        e.disp = to_bcd(cs);
        e.run  = run;
        e.lapa = lapa;
        e.lapc = 4'(lapc);
        e.tout = tout;
        e.dn   = dn;
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            automatic exp_t e = sb_q.pop_front();
            if (e.due != cyc) check_eq({e.tag, ".late"}, cyc, e.due);
            check_eq({e.tag, ".disp"}, 32'(disp_bcd), 32'(e.disp));
            check_eq({e.tag, ".running"}, 32'(running), 32'(e.run));
            check_eq({e.tag, ".lap_active"}, 32'(lap_active), 32'(e.lapa));
            check_eq({e.tag, ".lap_count"}, 32'(lap_count), 32'(e.lapc));
            check_eq({e.tag, ".time_out"}, 32'(time_out), 32'(e.tout));
            check_eq({e.tag, ".done"}, 32'(done), 32'(e.dn));
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [23:0] v);
        load_bcd = v; load = 1'b1; step(1); load = 1'b0;
    endtask

    initial begin
        step(2);
        expect_at(1, "reset", 0, 0, 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        step(2);

        // Up count to the 10 s alarm threshold.
        pulse_start();
        expect_at(TickDiv * 1000, "up_999", 999, 1, 0, 0, 0, 0);
        expect_at(TickDiv * 1000 + 1, "up_1000", 1000, 1, 0, 0, 1, 0);
        step(TickDiv * 1000 + 1);
        clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
        expect_at(1, "clr_start", 0, 0, 0, 0, 0, 0);
        expect_at(20, "clr_hold", 0, 0, 0, 0, 0, 0);
        step(20);

        // Laps at 00:03.27 and 00:05.00, then stop and release.
        pulse_start();
        step(1309);
        lap = 1'b1; step(1); lap = 1'b0;
        expect_at(1, "lap1", 327, 1, 1, 1, 0, 0);
        expect_at(90, "lap1_hold", 327, 1, 1, 1, 0, 0);
        step(90);
        step(601);
        lap = 1'b1; step(1); lap = 1'b0;
        expect_at(1, "lap2", 500, 1, 1, 2, 0, 0);
        step(1);
        pulse_start();
        lap = 1'b1; step(1); lap = 1'b0;
        expect_at(1, "stop_lap", 501, 0, 0, 2, 0, 0);
        step(1);
        pulse_clear();

        // Saturating load to all-max, wrap, then stop mid-tick and resume.
        pulse_load(24'h9F9F9F);
        expect_at(1, "load_sat", 359999, 0, 0, 0, 1, 0);
        step(1);
        pulse_start();
        expect_at(4, "wrap_pre", 359999, 1, 0, 0, 1, 0);
        expect_at(5, "wrap", 0, 1, 0, 0, 0, 0);
        step(5);
        pulse_start();
        step(10);
        pulse_start();
        expect_at(2, "resume_pre", 0, 1, 0, 0, 0, 0);
        expect_at(3, "resume", 1, 1, 0, 0, 0, 0);
        step(3);
        pulse_clear();

        // Countdown to DONE.
        mode_down = 1'b1;
        pulse_start();
        expect_at(5, "dn_zero_ign", 0, 0, 0, 0, 0, 0);
        step(5);
        pulse_load(24'h000005);
        pulse_start();
        expect_at(10, "cd_mid", 3, 1, 0, 0, 1, 0);
        expect_at(21, "cd_done", 0, 0, 0, 0, 0, 1);
        step(21);
        pulse_start();
        expect_at(8, "done_ign", 0, 0, 0, 0, 0, 1);
        step(8);
        pulse_load(24'h000003);
        expect_at(1, "reload", 3, 0, 0, 0, 1, 0);
        step(1);
        pulse_start();
        expect_at(13, "cd2_done", 0, 0, 0, 0, 0, 1);
        step(13);
        pulse_clear();
        mode_down = 1'b0;

        // Asynchronous reset while running.
        pulse_start();
        expect_at(49, "pre_rst", 12, 1, 0, 0, 0, 0);
        step(50);
        rst = 1'b1;
        #1;
        check_eq("rst_async.disp", 32'(disp_bcd), 32'd0);
        check_eq("rst_async.running", 32'(running), 32'd0);
        check_eq("rst_async.time_out", 32'(time_out), 32'd0);
        step(3);
        rst = 1'b0;
        expect_at(20, "post_rst", 0, 0, 0, 0, 0, 0);
        step(20);

`ifdef LAP_HISTORY_EN
        begin
            int unsigned at = 0;
            pulse_start();
            for (int j = 1; j <= 5; j++) begin
                step(40 * j + 1 - at);
                lap = 1'b1; step(1); lap = 1'b0;
                at = 40 * j + 2;
            end
            check_eq("hist.lap_count", 32'(lap_count), 32'd5);
            hist_idx = 2'd0; step(2);
            check_eq("hist0", 32'(hist_bcd), 32'(to_bcd(50)));
            hist_idx = 2'd1; step(2);
            check_eq("hist1", 32'(hist_bcd), 32'(to_bcd(40)));
            hist_idx = 2'd3; step(2);
            check_eq("hist3", 32'(hist_bcd), 32'(to_bcd(20)));
        end
`endif

        step(2);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
